credit_tx: RTL and testbench

CREDIT_TX -- requirements
Module: credit_tx

---
 rtl/dti_credit_pkg.sv | 10 +
 rtl/dti.sv | 12 +
 rtl/credit_counter.sv | 37 +++
 rtl/credit_tx.sv | 52 +++++
 tb/tb_credit_tx.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dti_credit_pkg.sv
// Shared helpers for the credit-based stream link.
// Used by both the transmitter and the companion receiver.
package dti_credit_pkg;

    // Bits needed to hold a credit count in the range 0..depth.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dti.sv
// Valid/ready/data stream bundle.
// The producer drives valid/data; the consumer drives ready.
interface dti #(
    parameter int W = 16
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/credit_counter.sv
// Credit count with saturation at DEPTH and a sticky overflow flag.
// The caller only asserts dec while the count is nonzero.
module credit_counter
    import dti_credit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = credit_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          nonzero,
    output logic          full,
    output logic          overflow
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    assign nonzero = (count != '0);
    assign full    = (count == FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= FULL;
            overflow <= 1'b0;
        end else if (dec && !inc) begin
            count <= count - 1'b1;
        end else if (inc && !dec) begin
            // A credit beyond DEPTH means the remote side miscounted.
            if (full) overflow <= 1'b1;
            else      count    <= count + 1'b1;
        end
    end

endmodule

// File: rtl/credit_tx.sv
// Credit-based link transmitter: registers one word per transfer
// and only accepts data while the remote buffer has room.
module credit_tx
    import dti_credit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DIN   = 16,
    localparam int CW = credit_width(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    dti.consumer           din,
    output logic           tx_valid,
    output logic [DIN-1:0] tx_data,
    input  logic           credit_in,
    output logic [CW-1:0]  credits,
    output logic           idle,
    output logic           overflow
);

    logic xfer;
    logic nonzero;
    logic full;

    assign din.ready = nonzero;
    assign xfer      = din.valid && nonzero;
    assign idle      = full && !tx_valid;

    credit_counter #(
        .DEPTH (DEPTH)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .dec      (xfer),
        .inc      (credit_in),
        .count    (credits),
        .nonzero  (nonzero),
        .full     (full),
        .overflow (overflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_valid <= xfer;
            if (xfer) tx_data <= din.data;
        end
    end

endmodule

// File: tb/tb_credit_tx.sv
// Bench for credit_tx: directed scenarios plus a random run
// against a remote receive-FIFO model.
module tb_credit_tx;

    logic        clk;
    logic        rst;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        credit_in;
    logic [1:0]  credits;
    logic        idle;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    dti #(.W(16)) bus ();

    credit_tx #(
        .DEPTH (2),
        .DIN   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (bus),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .credit_in (credit_in),
        .credits   (credits),
        .idle      (idle),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ready, tx_valid, tx_data, credits, idle, overflow}
    function automatic logic [21:0] snap();
        return {bus.ready, tx_valid, tx_data, credits, idle, overflow};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d,
                         input logic ci);
        bus.valid = v;
        bus.data  = d;
        credit_in = ci;
    endtask

    task automatic test_reset();
        logic [21:0] e;
        rst = 1'b1;
        drive(1'b1, 16'hAAAA, 1'b1);
        tick();
        e = {1'b1, 1'b0, 16'h0000, 2'd2, 1'b1, 1'b0};
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", snap(), e);
        end
        rst = 1'b0;
        drive(1'b0, 16'h0000, 1'b0);
        tick();
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", snap(), e);
        end
    endtask

    task automatic test_stream();
        logic [21:0] e;
        drive(1'b1, 16'h0001, 1'b0);
        tick();
        e = {1'b1, 1'b1, 16'h0001, 2'd1, 1'b0, 1'b0};
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL stream_w1: got %h want %h", snap(), e);
        end
        drive(1'b1, 16'h0002, 1'b0);
        tick();
        e = {1'b0, 1'b1, 16'h0002, 2'd0, 1'b0, 1'b0};
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL stream_w2: got %h want %h", snap(), e);
        end
        drive(1'b1, 16'h0003, 1'b0);
        tick();
        e = {1'b0, 1'b0, 16'h0002, 2'd0, 1'b0, 1'b0};
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL stream_stall: got %h want %h", snap(), e);
        end
        tick();
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL stream_stall2: got %h want %h", snap(), e);
        end
    endtask

    task automatic test_credit_return();
        logic [21:0] e;
        drive(1'b1, 16'h0003, 1'b1);
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_no_bypass: got %b want 0", bus.ready);
        end
        tick();
        e = {1'b1, 1'b0, 16'h0002, 2'd1, 1'b0, 1'b0};
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL credit_ret: got %h want %h", snap(), e);
        end
        drive(1'b1, 16'h0003, 1'b0);
        tick();
        e = {1'b0, 1'b1, 16'h0003, 2'd0, 1'b0, 1'b0};
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL credit_send3: got %h want %h", snap(), e);
        end
        drive(1'b0, 16'h0000, 1'b0);
        tick();
        e = {1'b0, 1'b0, 16'h0003, 2'd0, 1'b0, 1'b0};
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL credit_after: got %h want %h", snap(), e);
        end
    endtask

    task automatic test_coincide();
        logic [21:0] e;
        drive(1'b0, 16'h0000, 1'b1);
        tick();
        drive(1'b1, 16'h1234, 1'b1);
        tick();
        e = {1'b1, 1'b1, 16'h1234, 2'd1, 1'b0, 1'b0};
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL coincide: got %h want %h", snap(), e);
        end
        drive(1'b0, 16'h0000, 1'b0);
        tick();
        e = {1'b1, 1'b0, 16'h1234, 2'd1, 1'b0, 1'b0};
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL coincide_hold: got %h want %h", snap(), e);
        end
        drive(1'b0, 16'h0000, 1'b1);
        tick();
        e = {1'b1, 1'b0, 16'h1234, 2'd2, 1'b1, 1'b0};
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL coincide_full: got %h want %h", snap(), e);
        end
    endtask

    task automatic test_overflow();
        logic [21:0] e;
        drive(1'b0, 16'h0000, 1'b1);
        tick();
        e = {1'b1, 1'b0, 16'h1234, 2'd2, 1'b1, 1'b1};
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL ovf_set: got %h want %h", snap(), e);
        end
        drive(1'b1, 16'h0055, 1'b0);
        tick();
        e = {1'b1, 1'b1, 16'h0055, 2'd1, 1'b0, 1'b1};
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL ovf_sticky: got %h want %h", snap(), e);
        end
        drive(1'b0, 16'h0000, 1'b1);
        tick();
        drive(1'b0, 16'h0000, 1'b0);
        tick();
        e = {1'b1, 1'b0, 16'h0055, 2'd2, 1'b1, 1'b1};
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL ovf_sticky2: got %h want %h", snap(), e);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e = {1'b1, 1'b0, 16'h0000, 2'd2, 1'b1, 1'b0};
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL ovf_clear: got %h want %h", snap(), e);
        end
    endtask

    task automatic test_reset_midstream();
        logic [21:0] e;
        drive(1'b1, 16'hBEEF, 1'b0);
        tick();
        e = {1'b1, 1'b1, 16'hBEEF, 2'd1, 1'b0, 1'b0};
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL mid_send: got %h want %h", snap(), e);
        end
        rst = 1'b1;
        drive(1'b1, 16'h7777, 1'b1);
        tick();
        rst = 1'b0;
        drive(1'b0, 16'h0000, 1'b0);
        e = {1'b1, 1'b0, 16'h0000, 2'd2, 1'b1, 1'b0};
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL mid_rst: got %h want %h", snap(), e);
        end
        tick();
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL mid_after: got %h want %h", snap(), e);
        end
    endtask

    // Remote side: a 2-entry FIFO drained at random, each pop
    // returning one credit after a random delay.
    task automatic test_random();
        logic [15:0] rxq[$];
        logic [15:0] sentq[$];
        int          credq[$];
        int          outstanding = 0;
        int          last_due = 0;
        logic [15:0] last_tx = 16'h0000;
        logic [15:0] got;
        logic [15:0] want;
        logic [15:0] d;
        logic        v;
        logic        ci;
        logic        exp_rdy;
        logic        drain;
        int          due;
        int          nrx = 0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            drain = (cyc >= 500);
            exp_rdy = (outstanding < 2);
            checks++;
            if (credits !== 2'(2 - outstanding) || bus.ready !== exp_rdy) begin
                errors++;
                $display("FAIL rnd_credits cyc %0d: got %0d/%b want %0d/%b",
                         cyc, credits, bus.ready, 2 - outstanding, exp_rdy);
            end
            if (tx_valid) begin
                rxq.push_back(tx_data);
                last_tx = tx_data;
                checks++;
                if (rxq.size() > 2) begin
                    errors++;
                    $display("FAIL rnd_fifo_depth cyc %0d: got %0d want <=2",
                             cyc, rxq.size());
                end
            end else begin
                checks++;
                if (tx_data !== last_tx) begin
                    errors++;
                    $display("FAIL rnd_hold cyc %0d: got %h want %h",
                             cyc, tx_data, last_tx);
                end
            end
            if (rxq.size() > 0 && (drain || $urandom_range(0, 2) == 0)) begin
                got = rxq.pop_front();
                nrx++;
                want = (sentq.size() > 0) ? sentq.pop_front() : ~got;
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL rnd_data cyc %0d: got %h want %h",
                             cyc, got, want);
                end
                due = cyc + $urandom_range(0, 3);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                credq.push_back(due);
            end
            ci = (credq.size() > 0 && credq[0] <= cyc);
            if (ci) void'(credq.pop_front());
            v = !drain && ($urandom_range(0, 1) == 1);
            d = 16'($urandom);
            if (v && exp_rdy) begin
                sentq.push_back(d);
                outstanding++;
            end
            if (ci) outstanding--;
            drive(v, d, ci);
            tick();
        end
        checks++;
        if (sentq.size() != 0 || rxq.size() != 0 || credq.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain: got %0d/%0d/%0d left want 0/0/0",
                     sentq.size(), rxq.size(), credq.size());
        end
        checks++;
        if (overflow !== 1'b0 || credits !== 2'd2 || idle !== 1'b1) begin
            errors++;
            $display("FAIL rnd_end: got ovf %b cr %0d idle %b want 0 2 1",
                     overflow, credits, idle);
        end
        checks++;
        if (nrx < 50) begin
            errors++;
            $display("FAIL rnd_traffic: got %0d words want >=50", nrx);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0);
        test_reset();
        test_stream();
        test_credit_return();
        test_coincide();
        test_overflow();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
